// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared AHB encodings and arbiter state type for the per-slave arbiter.
// Beat-count decoding for fixed-length bursts lives here as well.
package ahb_slave_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } hburst_t;

  typedef enum logic [1:0] {
    FREE,
    OWNED,
    BURST_FIX,
    BURST_INC
  } arb_state_t;

  function automatic logic [3:0] burst_beats_m1(input hburst_t b);
    case (b)
      WRAP4,  INCR4:  return 4'd3;
      WRAP8,  INCR8:  return 4'd7;
      WRAP16, INCR16: return 4'd15;
      default:        return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_slave_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester searched from ptr+1
// upward, wrapping modulo CHANNEL_NUM.
module ahb_rr_pick #(
  parameter int unsigned CHANNEL_NUM = 2
) (
  input  logic [CHANNEL_NUM-1:0]                              req,
  input  logic [((CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1)-1:0] ptr,
  output logic [CHANNEL_NUM-1:0]                              grant,
  output logic                                                valid
);

  localparam int unsigned PTR_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

  always_comb begin
    int unsigned idx;
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= CHANNEL_NUM; i++) begin
      idx = (32'(ptr) + i) % CHANNEL_NUM;
      if (!valid && req[idx[PTR_W-1:0]]) begin
        grant[idx[PTR_W-1:0]] = 1'b1;
        valid                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: round-robin ownership of one slave port with
// burst locking, registered address/data-phase selects.
module ahb_slave_arbiter
  import ahb_slave_arbiter_pkg::*;
#(
  parameter int unsigned CHANNEL_NUM = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [CHANNEL_NUM-1:0]   req,
  input  logic [2*CHANNEL_NUM-1:0] htrans_in,
  input  logic [3*CHANNEL_NUM-1:0] hburst_in,
  input  logic                     hready_slave,
  output logic [CHANNEL_NUM-1:0]   addr_sel,
  output logic [CHANNEL_NUM-1:0]   data_sel,
  output logic [CHANNEL_NUM-1:0]   master_wait
);

  localparam int unsigned PTR_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

  arb_state_t             state, state_nxt;
  logic [CNT_W-1:0]       beat_cnt, cnt_nxt;
  logic [PTR_W-1:0]       ptr, ptr_nxt, win_idx;
  logic [CHANNEL_NUM-1:0] sel_nxt, grant;
  logic                   grant_valid;
  logic [1:0]             own_trans;
  logic [2:0]             own_burst;
  logic                   own_req;
  logic                   own_burst_start;
  logic                   ap;

  ahb_rr_pick #(.CHANNEL_NUM(CHANNEL_NUM)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (grant),
    .valid (grant_valid)
  );

  always_comb begin
    own_trans = '0;
    own_burst = '0;
    own_req   = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
      if (addr_sel[i]) begin
        own_trans = own_trans | htrans_in[2*i +: 2];
        own_burst = own_burst | hburst_in[3*i +: 3];
        own_req   = own_req | req[i];
      end
      if (grant[i]) win_idx = PTR_W'(i);
    end
  end

  assign own_burst_start = (own_trans == NONSEQ) && (own_burst != SINGLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = beat_cnt;
    ptr_nxt   = ptr;
    sel_nxt   = addr_sel;
    ap        = 1'b0;
    if (hready_slave) begin
      unique case (state)
        FREE: ap = 1'b1;
        OWNED: begin
          if (own_req && own_burst_start) begin
            cnt_nxt   = CNT_W'(burst_beats_m1(hburst_t'(own_burst)));
            state_nxt = (own_burst == INCR) ? BURST_INC : BURST_FIX;
          end else begin
            ap = 1'b1;
          end
        end
        // The count is beats still to come after the NONSEQ; the SEQ that
        // takes it to zero is the final accepted beat and is the AP itself.
        BURST_FIX: begin
          if (!own_req || (own_trans == SEQ && beat_cnt <= CNT_W'(1)))
            ap = 1'b1;
          else if (own_trans == SEQ)
            cnt_nxt = beat_cnt - CNT_W'(1);
        end
        BURST_INC: begin
          if (!own_req || own_trans == IDLE || own_trans == NONSEQ)
            ap = 1'b1;
        end
      endcase

      if (ap) begin
        cnt_nxt = '0;
        if (grant_valid) begin
          sel_nxt   = grant;
          ptr_nxt   = win_idx;
          state_nxt = OWNED;
          // An INCR owner re-winning with a new NONSEQ burst must lock now,
          // since the NONSEQ beat is accepted in this very cycle.
          if (grant == addr_sel && own_burst_start) begin
            cnt_nxt   = CNT_W'(burst_beats_m1(hburst_t'(own_burst)));
            state_nxt = (own_burst == INCR) ? BURST_INC : BURST_FIX;
          end
        end else begin
          sel_nxt   = '0;
          state_nxt = FREE;
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= FREE;
      beat_cnt <= '0;
      ptr      <= PTR_W'(CHANNEL_NUM - 1);
      addr_sel <= '0;
      data_sel <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= cnt_nxt;
      ptr      <= ptr_nxt;
      addr_sel <= sel_nxt;
      if (hready_slave) data_sel <= addr_sel;
    end
  end

  assign master_wait = req & ~addr_sel;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed-vector bench for ahb_slave_arbiter with two masters.
module tb_ahb_slave_arbiter;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000, B_INCR = 3'b001, B_INCR4 = 3'b011,
                         B_INCR8 = 3'b101, B_INCR16 = 3'b111;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic [1:0] req;
  logic [3:0] htrans_in;
  logic [5:0] hburst_in;
  logic       hready_slave;
  logic [1:0] addr_sel, data_sel, master_wait;

  int vectors = 0;
  int miscompares = 0;

  ahb_slave_arbiter #(.CHANNEL_NUM(2), .CNT_W(4)) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .req          (req),
    .htrans_in    (htrans_in),
    .hburst_in    (hburst_in),
    .hready_slave (hready_slave),
    .addr_sel     (addr_sel),
    .data_sel     (data_sel),
    .master_wait  (master_wait)
  );

  always #5 HCLK = ~HCLK;

  task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_m(input int unsigned m, input logic r, input logic [1:0] t, input logic [2:0] b);
    req[m]            = r;
    htrans_in[2*m +: 2] = t;
    hburst_in[3*m +: 3] = b;
  endtask

  task automatic do_reset();
    HRESETn      = 1'b0;
    req          = '0;
    htrans_in    = '0;
    hburst_in    = '0;
    hready_slave = 1'b1;
    tick();
    check_vec("rst_addr_sel", addr_sel, 8'h0);
    check_vec("rst_data_sel", data_sel, 8'h0);
    check_vec("rst_wait", master_wait, 8'h0);
    HRESETn = 1'b1;
  endtask

  initial begin
    // Single transfer from master 0: grant latency and data-phase offset
    do_reset();
    set_m(0, 1'b1, T_NS, B_SINGLE);
    #1 check_vec("s1_wait_pre", master_wait, 8'h1);
    tick();
    check_vec("s1_addr", addr_sel, 8'h1);
    check_vec("s1_data0", data_sel, 8'h0);
    check_vec("s1_wait_post", master_wait, 8'h0);
    tick();
    check_vec("s1_addr_keep", addr_sel, 8'h1);
    check_vec("s1_data1", data_sel, 8'h1);
    set_m(0, 1'b0, T_IDLE, B_SINGLE);
    tick();
    check_vec("s1_release", addr_sel, 8'h0);
    check_vec("s1_data_tail", data_sel, 8'h1);
    tick();
    check_vec("s1_data_idle", data_sel, 8'h0);

    // Simultaneous singles: strict alternation starting at master 0
    do_reset();
    set_m(0, 1'b1, T_NS, B_SINGLE);
    set_m(1, 1'b1, T_NS, B_SINGLE);
    tick();
    check_vec("rr_first", addr_sel, 8'h1);
    check_vec("rr_wait", master_wait, 8'h2);
    tick();
    check_vec("rr_second", addr_sel, 8'h2);
    tick();
    check_vec("rr_third", addr_sel, 8'h1);

    // INCR4 on master 0 with BUSY and two wait states; master 1 queued
    do_reset();
    set_m(0, 1'b1, T_NS, B_INCR4);
    tick();
    check_vec("b4_grant", addr_sel, 8'h1);
    set_m(1, 1'b1, T_NS, B_SINGLE);
    tick();                                  // NONSEQ accepted, count loads 3
    check_vec("b4_ns", addr_sel, 8'h1);
    check_vec("b4_wait_ns", master_wait, 8'h2);
    set_m(0, 1'b1, T_SEQ, B_INCR4);
    tick();                                  // 3 -> 2
    check_vec("b4_seq1", addr_sel, 8'h1);
    set_m(0, 1'b1, T_BUSY, B_INCR4);
    tick();
    check_vec("b4_busy", addr_sel, 8'h1);
    set_m(0, 1'b1, T_SEQ, B_INCR4);
    hready_slave = 1'b0;
    tick();
    check_vec("b4_ws1", addr_sel, 8'h1);
    tick();
    check_vec("b4_ws2", addr_sel, 8'h1);
    check_vec("b4_wait_ws", master_wait, 8'h2);
    hready_slave = 1'b1;
    tick();                                  // 2 -> 1
    check_vec("b4_seq2", addr_sel, 8'h1);
    tick();                                  // last beat, arbitration
    check_vec("b4_handover", addr_sel, 8'h2);
    check_vec("b4_data", data_sel, 8'h1);

    // Wait states during master 1 ownership freeze both selects
    set_m(0, 1'b1, T_NS, B_SINGLE);
    hready_slave = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_vec("ws_addr", addr_sel, 8'h2);
      check_vec("ws_data", data_sel, 8'h1);
    end
    hready_slave = 1'b1;
    tick();
    check_vec("ws_resume_addr", addr_sel, 8'h1);
    check_vec("ws_resume_data", data_sel, 8'h2);

    // Master 1 INCR ended by IDLE hands over to master 0
    do_reset();
    set_m(1, 1'b1, T_NS, B_INCR);
    tick();
    check_vec("inc_grant", addr_sel, 8'h2);
    set_m(0, 1'b1, T_NS, B_SINGLE);
    tick();
    check_vec("inc_ns", addr_sel, 8'h2);
    set_m(1, 1'b1, T_SEQ, B_INCR);
    tick();
    check_vec("inc_seq", addr_sel, 8'h2);
    check_vec("inc_wait", master_wait, 8'h1);
    set_m(1, 1'b0, T_IDLE, B_INCR);
    tick();
    check_vec("inc_idle_handover", addr_sel, 8'h1);

    // Master 1 abandons INCR8 at count 5
    do_reset();
    set_m(1, 1'b1, T_NS, B_INCR8);
    tick();
    set_m(0, 1'b1, T_NS, B_SINGLE);
    tick();                                  // count 7
    set_m(1, 1'b1, T_SEQ, B_INCR8);
    tick();                                  // 6
    tick();                                  // 5
    check_vec("i8_mid", addr_sel, 8'h2);
    set_m(1, 1'b0, T_IDLE, B_INCR8);
    tick();
    check_vec("i8_early_term", addr_sel, 8'h1);

    // Asynchronous reset in the middle of INCR16 at count 9
    do_reset();
    set_m(0, 1'b1, T_NS, B_INCR16);
    tick();
    set_m(1, 1'b1, T_NS, B_SINGLE);
    tick();                                  // count 15
    set_m(0, 1'b1, T_SEQ, B_INCR16);
    for (int k = 0; k < 6; k++) tick();      // 15 -> 9
    check_vec("i16_mid_addr", addr_sel, 8'h1);
    check_vec("i16_mid_data", data_sel, 8'h1);
    #1 HRESETn = 1'b0;
    #1;
    check_vec("i16_async_addr", addr_sel, 8'h0);
    check_vec("i16_async_data", data_sel, 8'h0);
    HRESETn = 1'b1;
    set_m(0, 1'b1, T_NS, B_SINGLE);
    tick();
    check_vec("i16_after_rst", addr_sel, 8'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
